// File: rtl/dpsk_pkg.sv
// rtl/dpsk_pkg.sv - mode constants and Gray mapping tables for the DPSK sync decoder
package dpsk_pkg;

  localparam int MODE_DBPSK = 0;
  localparam int MODE_DQPSK = 1;

  // Quadrant sign pair {dq<0, di<0} to absolute phase index.
  function automatic logic [1:0] cd_to_p(input logic [1:0] cd);
    case (cd)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] d_to_ab(input logic [1:0] d);
    case (d)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through symbol FIFO with full/empty flags
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a push.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/dpsk_sync_decoder.sv
// rtl/dpsk_sync_decoder.sv - symbol-strobed differential PSK decoder with lock detector
module dpsk_sync_decoder
  import dpsk_pkg::*;
#(
  parameter int W        = 26,
  parameter int MODE     = 1,
  parameter int DEPTH    = 4,
  parameter int LOCK_WIN = 64,
  parameter int LOCK_THR = 56
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] di,
  input  logic signed [W-1:0] dq,
  input  logic                sync_in,
  output logic [1:0]          dout,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic                lock,
  output logic                overflow
);

  localparam int           CW      = $clog2(LOCK_WIN + 1);
  localparam logic [W-1:0] MAG_MAX = {1'b0, {(W-1){1'b1}}};

  function automatic logic [W-1:0] sat_abs(input logic [W-1:0] v);
    if (v[W-1] && (v[W-2:0] == '0)) return MAG_MAX;
    return v[W-1] ? (~v + W'(1)) : v;
  endfunction

  logic          sync_d_q;
  logic          cap_q;
  logic [1:0]    cd_q;
  logic [W-1:0]  mag_i_q;
  logic [W-1:0]  mag_q_q;
  logic          ref_ok_q;
  logic [1:0]    p_prev_q;
  logic          sign_prev_q;
  logic          push_q;
  logic [1:0]    push_data_q;
  logic [CW-1:0] win_cnt_q;
  logic [CW-1:0] good_cnt_q;
  logic          lock_q;
  logic          overflow_q;

  logic          strobe;
  logic [1:0]    p_cur;
  logic [1:0]    ab_d;
  logic [W-1:0]  mag_hi;
  logic [W-1:0]  mag_lo;
  logic          good_d;
  logic [CW-1:0] good_cnt_d;
  logic          win_end;
  logic          fifo_full;
  logic          fifo_empty;

  assign strobe = sync_d_q && !sync_in;
  assign p_cur  = cd_to_p(cd_q);
  assign mag_hi = (mag_i_q >= mag_q_q) ? mag_i_q : mag_q_q;
  assign mag_lo = (mag_i_q >= mag_q_q) ? mag_q_q : mag_i_q;

  // DBPSK compares in W+1 bits so doubling |dq| can never wrap.
  assign ab_d   = (MODE == MODE_DQPSK) ? d_to_ab(p_cur - p_prev_q)
                                       : {1'b0, cd_q[0] ^ sign_prev_q};
  assign good_d = (MODE == MODE_DQPSK) ? (mag_lo >= (mag_hi >> 1))
                                       : ({1'b0, mag_i_q} >= {mag_q_q, 1'b0});

  assign good_cnt_d = good_cnt_q + CW'(good_d);
  assign win_end    = (win_cnt_q == CW'(LOCK_WIN - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_d_q    <= 1'b0;
      cap_q       <= 1'b0;
      cd_q        <= '0;
      mag_i_q     <= '0;
      mag_q_q     <= '0;
      ref_ok_q    <= 1'b0;
      p_prev_q    <= '0;
      sign_prev_q <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      win_cnt_q   <= '0;
      good_cnt_q  <= '0;
      lock_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_d_q <= sync_in;
      cap_q    <= strobe;
      if (strobe) begin
        cd_q    <= {dq[W-1], di[W-1]};
        mag_i_q <= sat_abs(di);
        mag_q_q <= sat_abs(dq);
      end
      // The first captured symbol only seeds the differential reference.
      push_q <= cap_q && ref_ok_q;
      if (cap_q) begin
        push_data_q <= ab_d;
        ref_ok_q    <= 1'b1;
        p_prev_q    <= p_cur;
        sign_prev_q <= cd_q[0];
        if (win_end) begin
          lock_q     <= (good_cnt_d >= CW'(LOCK_THR));
          win_cnt_q  <= '0;
          good_cnt_q <= '0;
        end else begin
          win_cnt_q  <= win_cnt_q + 1'b1;
          good_cnt_q <= good_cnt_d;
        end
      end
      if (push_q && fifo_full && !(dout_valid && dout_ready)) begin
        overflow_q <= 1'b1;
      end
    end
  end

  sync_fifo #(
    .WIDTH (2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_q),
    .data_i  (push_data_q),
    .pop_i   (dout_ready),
    .data_o  (dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign dout_valid = !fifo_empty;
  assign lock       = lock_q;
  assign overflow   = overflow_q;

endmodule

// File: doc/dpsk_sync_decoder.md
DPSK_SYNC_DECODER -- requirements
Module: dpsk_sync_decoder

Interface
REQ-001 SHALL have parameter W, default 26: signed width of di/dq soft-decision inputs.
REQ-002 SHALL have parameter MODE, default 1: 0 = DBPSK, 1 = DQPSK.
REQ-003 SHALL have parameter DEPTH, default 4: output FIFO depth in symbols, a power of two, >= 2.
REQ-004 SHALL have parameter LOCK_WIN, default 64: lock-detector window in symbols.
REQ-005 SHALL have parameter LOCK_THR, default 56: good-symbol count required for lock, <= LOCK_WIN.
REQ-006 SHALL have port clk, input, 1: the single system clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-008 SHALL have port di, input, W: signed in-phase loop output.
REQ-009 SHALL have port dq, input, W: signed quadrature loop output.
REQ-010 SHALL have port sync_in, input, 1: bit-sync level in the clk domain; its falling edge marks a symbol centre.
REQ-011 SHALL have port dout, output, 2: decoded absolute symbol {a,b}; a = 0 in DBPSK.
REQ-012 SHALL have port dout_valid, output, 1: FIFO head valid.
REQ-013 SHALL have port dout_ready, input, 1: consumer accept; a pop occurs when dout_valid && dout_ready.
REQ-014 SHALL have port lock, output, 1: carrier-lock indication.
REQ-015 SHALL have port overflow, output, 1: sticky flag, set when a symbol is dropped on a full FIFO.

Function
REQ-016 SHALL register sync_in once (sync_d) and define a strobe when sync_d = 1 and sync_in = 0.
REQ-017 On strobe, SHALL capture cd = {dq[W-1], di[W-1]}, plus saturated magnitudes |di| and |dq|; abs(-2^(W-1)) = 2^(W-1)-1.
REQ-018 SHALL map DQPSK cd to phase index p: 00->0, 01->1, 11->2, 10->3.
REQ-019 SHALL compute d = (p - p_prev) mod 4 and output ab: 0->00, 1->01, 2->11, 3->10.
REQ-020 In DBPSK, SHALL output ab = {0, cd[0] ^ cd_prev[0]}; cd[1] is ignored.
REQ-021 SHALL use the first strobe after reset only to load the reference (p_prev / cd_prev); that strobe writes no symbol.
REQ-022 Latency: the strobe at clk edge k SHALL make the symbol visible at the FIFO head (dout_valid = 1 if FIFO was empty) after edge k+2.
REQ-023 FIFO SHALL be first-word-fall-through; dout SHALL hold stable while dout_valid = 1 and dout_ready = 0.
REQ-024 Full FIFO with a push and no pop: SHALL drop the new symbol, keep stored data, and set overflow; p_prev still updates.
REQ-025 Full FIFO with simultaneous push and pop: SHALL accept both; occupancy stays DEPTH; overflow is not set.
REQ-026 Empty FIFO: dout_valid = 0; dout_ready is ignored; no underflow state.
REQ-027 A good symbol in DQPSK SHALL satisfy min(|di|,|dq|) >= max(|di|,|dq|) >> 1.
REQ-028 A good symbol in DBPSK SHALL satisfy |di| >= 2*|dq|, computed with a W+1-bit compare and no overflow.
REQ-029 Lock counters SHALL count strobes (including the reference strobe) and good symbols.
REQ-030 At each window end (LOCK_WIN strobes), lock SHALL become (good >= LOCK_THR), then both counters clear; lock holds between evaluations.
REQ-031 Back-to-back strobes (every other clk) SHALL be sustained without loss when dout_ready = 1.

Reset
REQ-032 While rst = 0 at a clk edge: dout = 0, dout_valid = 0, lock = 0, overflow = 0, FIFO empty, sync_d = 0, reference cleared and re-armed per REQ-021, lock counters = 0.
REQ-033 Reset mid-operation SHALL discard buffered symbols and in-flight decisions; no strobe SHALL be detected in the first cycle after reset release unless sync_in falls after that release.

Structure
REQ-034 Package dpsk_pkg SHALL hold the MODE constants (MODE_DBPSK = 0, MODE_DQPSK = 1) and the cd->p and d->ab Gray tables.
REQ-035 SHALL instantiate one sub-module, sync_fifo (parametrised width 2, DEPTH, FWFT, full/empty outputs); decode and lock logic stay in the top.

Verification
REQ-036 DQPSK: cd sequence 00,01,11,10,00 with dout_ready = 1 -> dout 01,01,01,01; the first strobe produces no output.
REQ-037 DBPSK: di signs +,-,-,+ -> dout 00 (from -), 01... expected ab = 01,00,01; dq varied randomly has no effect.
REQ-038 DEPTH = 4, dout_ready = 0, 6 data strobes -> 4 stored, overflow = 1, then draining returns the first 4 symbols in order.
REQ-039 Full FIFO, push and pop in the same cycle -> both accepted, occupancy stays 4, overflow = 0.
REQ-040 LOCK_WIN = 64, LOCK_THR = 56: 60 good, 4 bad -> lock = 1 at window end; next window 50 good -> lock = 0.
REQ-041 di = -2^(W-1), dq = 0 in DBPSK -> |di| saturates, good symbol, no wrap; rst pulsed mid-burst -> dout_valid = 0 next cycle and FIFO empty.
